// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the register-file debug sequencer
package mips_pkg;

    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    localparam logic MODE_DUMP  = 1'b0;
    localparam logic MODE_CLEAR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ISSUE,
        ST_CAPTURE,
        ST_PRESENT,
        ST_DONE
    } dump_state_t;

endpackage

// File: rtl/regfile_dumper_if.sv
// rtl/regfile_dumper_if.sv - register-file spare port plus dump stream bundle
// master: the sequencer (drives rf_addr/rf_we/rf_wd and the out_* word, takes rf_rd and out_ready)
// slave : register file and stream consumer side
interface regfile_dumper_if;
    import mips_pkg::*;

    logic [AW-1:0] rf_addr;
    logic          rf_we;
    logic [DW-1:0] rf_wd;
    logic [DW-1:0] rf_rd;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_index;
    logic          out_last;

    modport master (
        output rf_addr, rf_we, rf_wd, out_valid, out_data, out_index, out_last,
        input  rf_rd, out_ready
    );

    modport slave (
        input  rf_addr, rf_we, rf_wd, out_valid, out_data, out_index, out_last,
        output rf_rd, out_ready
    );

endinterface

// File: rtl/mips_regfile.sv
// rtl/mips_regfile.sv - register file spare port: shared address, registered read, no reset
// Ports: clk; addr drives read and write; we/wd write at the rising edge; rd valid one cycle after addr
module mips_regfile
    import mips_pkg::*;
(
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [DW-1:0] wd,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wd;
        end
        rd <= mem[addr];
    end

endmodule

// File: rtl/regfile_dumper.sv
// rtl/regfile_dumper.sv - clears the register file or streams its contents out, one word per request
// Ports: clk; reset (async, active-low); start/mode request sampled in IDLE;
//        busy (not IDLE), done (one-cycle completion pulse);
//        bus (master): rf_addr/rf_we/rf_wd/rf_rd register-file port, out_* valid/ready dump stream
module regfile_dumper
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    regfile_dumper_if.master bus
);

    dump_state_t   state, state_nx;
    logic [AW-1:0] idx, idx_nx;
    logic [DW-1:0] data_q;
    logic [AW-1:0] index_q;
    logic          last_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            idx     <= '0;
            data_q  <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            // The register file answers the address issued last cycle; grab it here.
            if (state == ST_CAPTURE) begin
                data_q  <= bus.rf_rd;
                index_q <= idx;
                last_q  <= (idx == LAST_IDX);
            end
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    idx_nx   = '0;
                    state_nx = (mode == MODE_CLEAR) ? ST_CLEAR : ST_ISSUE;
                end
            end
            ST_CLEAR: begin
                // idx parks on the last register rather than wrapping.
                if (idx == LAST_IDX) begin
                    state_nx = ST_DONE;
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
            ST_ISSUE:   state_nx = ST_CAPTURE;
            ST_CAPTURE: state_nx = ST_PRESENT;
            ST_PRESENT: begin
                if (bus.out_ready) begin
                    if (idx == LAST_IDX) begin
                        state_nx = ST_DONE;
                    end else begin
                        idx_nx   = idx + 1'b1;
                        state_nx = ST_ISSUE;
                    end
                end
            end
            ST_DONE:    state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // rf_addr comes straight from the idx flop, so it only moves on clock edges.
    assign bus.rf_addr   = idx;
    assign bus.rf_we     = (state == ST_CLEAR);
    assign bus.rf_wd     = '0;
    assign bus.out_valid = (state == ST_PRESENT);
    assign bus.out_data  = data_q;
    assign bus.out_index = index_q;
    assign bus.out_last  = last_q && (state == ST_PRESENT);
    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_DONE);

endmodule

// File: doc/regfile_dumper.md
# regfile_dumper

Sequencer on the debug side of the MIPS register file: drives its address, write-enable and write-data ports and consumes its registered read data. On a start request it either clears all registers to zero (the register file has no reset) or reads them out one by one to a valid/ready debug stream. It sits between the debug/host controller and the register file's spare port, and runs only while the core is halted.

## Interface
- `NREGS`, 32: number of registers walked
- `AW`, 5: register address width
- `DW`, 32: data width
- `clk`  in  1  rising-edge clock, shared with the register file
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle request; sampled only in IDLE
- `mode`  in  1  sampled with `start`: 0 = dump, 1 = clear
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when an operation completes
- `rf_addr`  out  AW  register address; drives both the read and write address ports
- `rf_we`  out  1  register-file write enable (clear mode only)
- `rf_wd`  out  DW  write data; constant 0
- `rf_rd`  in  DW  register-file read data, valid one cycle after `rf_addr`
- `out_valid`  out  1  dump word available
- `out_ready`  in  1  consumer accepts the word
- `out_data`  out  DW  register contents
- `out_index`  out  AW  register number of `out_data`
- `out_last`  out  1  high with the word for index NREGS-1

## Operation
- States: IDLE, CLEAR, ISSUE, CAPTURE, PRESENT, DONE.
- IDLE: when `start`=1, latch `mode`, set idx=0, and go to CLEAR (mode 1) or ISSUE (mode 0).
- CLEAR: `rf_we`=1 and `rf_addr`=idx. Increment idx each cycle. After idx = NREGS-1, go to DONE. Register 0 is cleared too.
- ISSUE: `rf_addr`=idx and `rf_we`=0; go to CAPTURE.
- CAPTURE: register `rf_rd` into `out_data` and idx into `out_index`; go to PRESENT.
- PRESENT: `out_valid`=1. `out_data`, `out_index` and `out_last` stay stable until `out_valid && out_ready`.
  - On handshake with idx = NREGS-1: go to DONE.
  - Otherwise: idx+1, go to ISSUE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored, including in DONE. `mode` is ignored except when sampled with `start`.
- `out_ready` while `out_valid`=0 has no effect.
- `rf_addr` is a register holding idx; it never glitches between register accesses.
- idx is AW bits wide and never wraps: the terminal compare is against NREGS-1.
- Asynchronous reset, including mid-operation: immediately go to IDLE. `rf_we`, `busy`, `done`, `out_valid`, `out_last` = 0; `rf_addr`, `out_data`, `out_index`, idx = 0. A partial clear or dump is abandoned and no `done` is issued.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high.
- Clear:
  - `rf_we` is high in cycles 1..NREGS, with `rf_addr` = cycle-1.
  - `done` is in cycle NREGS+1; `busy` is low from cycle NREGS+2.
  - Total 34 cycles for NREGS=32.
- Dump, with `out_ready` held high:
  - Word k has `out_valid` in cycle 3+3k.
  - The last word (k=31) is in cycle 96, `done` in cycle 97.
- Each backpressure cycle delays all later words by one cycle.
- Read latency is exactly one cycle, matching the register file's registered outputs. Write takes effect at the rising edge ending the CLEAR cycle.

## Structure
- Shared package `mips_pkg`:
  - constants NREGS, AW, DW
  - state enum `dump_state_t`
  - mode encodings `MODE_DUMP`=0, `MODE_CLEAR`=1
- Single module with no sub-modules. The FSM and idx counter are small enough to stay inline.
- The bench instantiates the existing register file alongside this block.

## Test plan
- Reset values: hold `reset`=0 with random inputs → all outputs 0 and `busy`=0. Release → IDLE, no `done`.
- Clear: preload registers with 0xFFFFFFFF, pulse `start` with `mode`=1 → `rf_we` high for exactly 32 cycles, addresses 0..31 in order, `done` in cycle 33. A subsequent dump returns 32 zero words.
- Dump, no backpressure:
  - Preload register k with 0xA5000000+k, pulse `start` with `mode`=0, `out_ready`=1.
  - Expect 32 words in index order with `out_data`=0xA5000000+k.
  - Expect `out_last` only on index 31 and `done` in cycle 97.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles on word 7 → `out_valid`, `out_data`=0xA5000007 and `out_index`=7 stay stable.
  - Expect no `rf_addr` change and `done` 5 cycles late (cycle 102).
- Start while busy: pulse `start` with `mode`=1 during a dump, and again in the DONE cycle → both ignored. No `rf_we` and a single `done`.
- Reset mid-operation: assert `reset` during word 10 of a dump and in cycle 12 of a clear → outputs go to reset values immediately. A fresh dump afterwards starts at index 0.
